// File: rtl/peg_l2_mac_rx_ingress_ctrl.sv
// RMII receive ingress: writes accepted beats into the packet RAM, commits good packets as descriptors, drops the rest.
// Optional macro PEG_L2_MAC_RX_RUNT_FILTER_EN: when defined, error-free packets shorter than 64 bytes are dropped.
module peg_l2_mac_rx_ingress_ctrl #(
    parameter int PKT_DATA_W   = 8,
    parameter int PKT_SIZE_W   = 16,
    parameter int BUFF_ADDR_W  = 10,
    parameter int DESC_DEPTH_W = 2
) (
    input  logic                    rmii_ref_clk,
    input  logic                    rst_n,
    input  logic                    config_mac_rx_en,
    input  logic                    pkt_valid,
    input  logic                    pkt_sop,
    input  logic                    pkt_eop,
    input  logic                    pkt_error,
    input  logic [PKT_DATA_W-1:0]   pkt_data,
    output logic                    pkt_ready,
    output logic                    buff_wr_en,
    output logic [BUFF_ADDR_W-1:0]  buff_wr_addr,
    output logic [PKT_DATA_W-1:0]   buff_wr_data,
    output logic                    desc_valid,
    output logic [BUFF_ADDR_W-1:0]  desc_addr,
    output logic [PKT_SIZE_W-1:0]   desc_size,
    input  logic                    desc_ready,
    input  logic                    rel_valid,
    input  logic [PKT_SIZE_W-1:0]   rel_size,
    output logic [15:0]             drop_cntr
);

    localparam int BUFF_DEPTH = 1 << BUFF_ADDR_W;
    localparam int DESC_DEPTH = 1 << DESC_DEPTH_W;
    localparam int SUM_W      = PKT_SIZE_W + 2;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(BUFF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [BUFF_ADDR_W-1:0]   r_wptr;
    logic [BUFF_ADDR_W-1:0]   r_cptr;
    logic [BUFF_ADDR_W:0]     r_occ;
    logic [PKT_SIZE_W-1:0]    r_cur_size;
    logic                     r_wr_en;
    logic [BUFF_ADDR_W-1:0]   r_wr_addr;
    logic [PKT_DATA_W-1:0]    r_wr_data;
    logic [15:0]              r_drop_cntr;
    logic [BUFF_ADDR_W-1:0]   r_desc_addr_mem [DESC_DEPTH];
    logic [PKT_SIZE_W-1:0]    r_desc_size_mem [DESC_DEPTH];
    logic [DESC_DEPTH_W-1:0]  r_fifo_rd;
    logic [DESC_DEPTH_W-1:0]  r_fifo_wr;
    logic [DESC_DEPTH_W:0]    r_fifo_cnt;

    logic [BUFF_ADDR_W-1:0]   w_wptr_nxt;
    logic [BUFF_ADDR_W-1:0]   w_cptr_nxt;
    logic [PKT_SIZE_W-1:0]    w_cur_nxt;
    logic                     w_beat;
    logic [BUFF_ADDR_W-1:0]   w_bptr;
    logic [PKT_SIZE_W-1:0]    w_bcur;
    logic [PKT_SIZE_W-1:0]    w_fin_size;
    logic                     w_runt;
    logic                     w_push;
    logic [PKT_SIZE_W-1:0]    w_commit_size;
    logic [1:0]               w_drop_inc;
    logic                     w_sop_ok;
    logic                     w_fifo_full;
    logic                     w_pop;
    logic [SUM_W-1:0]         w_occ_sum;
    logic [SUM_W-1:0]         w_rel;
    logic [BUFF_ADDR_W:0]     w_occ_nxt;
    logic [16:0]              w_drop_sum;
    logic [15:0]              w_drop_nxt;

    // A beat fits when committed occupancy plus the in-flight bytes leaves at least one free byte.
    function automatic logic f_room(input logic [BUFF_ADDR_W:0] occ, input logic [PKT_SIZE_W-1:0] cur);
        f_room = (SUM_W'(occ) + SUM_W'(cur)) < DEPTH_S;
    endfunction

    assign w_fifo_full = (r_fifo_cnt == (DESC_DEPTH_W+1)'(DESC_DEPTH));
    assign w_pop       = (r_fifo_cnt != '0) & desc_ready;
    assign w_sop_ok    = config_mac_rx_en & ~w_fifo_full & f_room(r_occ, PKT_SIZE_W'(0));

    assign pkt_ready    = rst_n;
    assign buff_wr_en   = r_wr_en;
    assign buff_wr_addr = r_wr_addr;
    assign buff_wr_data = r_wr_data;
    assign desc_valid   = (r_fifo_cnt != '0);
    assign desc_addr    = r_desc_addr_mem[r_fifo_rd];
    assign desc_size    = r_desc_size_mem[r_fifo_rd];
    assign drop_cntr    = r_drop_cntr;

    // FSM state register.
    always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, pointer/size updates, write strobe, commit and drop decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_wptr_nxt    = r_wptr;
        w_cptr_nxt    = r_cptr;
        w_cur_nxt     = r_cur_size;
        w_beat        = 1'b0;
        w_bptr        = r_wptr;
        w_bcur        = r_cur_size;
        w_fin_size    = '0;
        w_runt        = 1'b0;
        w_push        = 1'b0;
        w_commit_size = '0;
        w_drop_inc    = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (pkt_valid & pkt_sop) begin
                    if (w_sop_ok) begin
                        w_beat = 1'b1;
                        w_bptr = r_cptr;
                        w_bcur = '0;
                    end else begin
                        w_drop_inc  = 2'd1;
                        w_state_nxt = pkt_eop ? ST_IDLE : ST_DROP;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (pkt_valid & pkt_sop) begin
                    // Abort the packet in flight, then handle this beat as a fresh start.
                    w_wptr_nxt = r_cptr;
                    w_cur_nxt  = '0;
                    if (w_sop_ok) begin
                        w_drop_inc = 2'd1;
                        w_beat     = 1'b1;
                        w_bptr     = r_cptr;
                        w_bcur     = '0;
                    end else begin
                        w_drop_inc  = 2'd2;
                        w_state_nxt = pkt_eop ? ST_IDLE : ST_DROP;
                    end
                end else if (pkt_valid) begin
                    if (f_room(r_occ, r_cur_size)) begin
                        w_beat = 1'b1;
                    end else begin
                        w_wptr_nxt  = r_cptr;
                        w_cur_nxt   = '0;
                        w_drop_inc  = 2'd1;
                        w_state_nxt = pkt_eop ? ST_IDLE : ST_DROP;
                    end
                end else begin
                    w_state_nxt = ST_RECV;
                end
            end
            ST_DROP: begin
                if (pkt_valid & pkt_eop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_beat) begin
            w_fin_size = w_bcur + PKT_SIZE_W'(1);
`ifdef PEG_L2_MAC_RX_RUNT_FILTER_EN
            w_runt = (w_fin_size < PKT_SIZE_W'(64));
`else
            w_runt = 1'b0;
`endif
            if (pkt_eop) begin
                w_state_nxt = ST_IDLE;
                w_cur_nxt   = '0;
                if (pkt_error | w_runt) begin
                    w_drop_inc = w_drop_inc + 2'd1;
                    w_wptr_nxt = r_cptr;
                end else begin
                    w_push        = 1'b1;
                    w_commit_size = w_fin_size;
                    w_wptr_nxt    = w_bptr + BUFF_ADDR_W'(1);
                    w_cptr_nxt    = w_bptr + BUFF_ADDR_W'(1);
                end
            end else begin
                w_state_nxt = ST_RECV;
                w_wptr_nxt  = w_bptr + BUFF_ADDR_W'(1);
                w_cur_nxt   = w_fin_size;
            end
        end else begin
            w_fin_size = '0;
        end
    end

    // Occupancy and saturating drop-count next values; release larger than occupancy clamps to zero.
    always_comb begin
        w_occ_sum = SUM_W'(r_occ) + SUM_W'(w_commit_size);
        if (rel_valid) begin
            w_rel = SUM_W'(rel_size);
        end else begin
            w_rel = '0;
        end
        if (w_rel > w_occ_sum) begin
            w_occ_nxt = '0;
        end else begin
            w_occ_nxt = (BUFF_ADDR_W+1)'(w_occ_sum - w_rel);
        end
        w_drop_sum = 17'(r_drop_cntr) + 17'(w_drop_inc);
        if (w_drop_sum[16]) begin
            w_drop_nxt = 16'hFFFF;
        end else begin
            w_drop_nxt = w_drop_sum[15:0];
        end
    end

    // Write/commit pointers, sizes, registered RAM write port and drop counter.
    always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_cptr      <= '0;
            r_occ       <= '0;
            r_cur_size  <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_drop_cntr <= 16'h0000;
        end else begin
            r_wptr      <= w_wptr_nxt;
            r_cptr      <= w_cptr_nxt;
            r_occ       <= w_occ_nxt;
            r_cur_size  <= w_cur_nxt;
            r_wr_en     <= w_beat;
            r_drop_cntr <= w_drop_nxt;
            if (w_beat) begin
                r_wr_addr <= w_bptr;
                r_wr_data <= pkt_data;
            end
        end
    end

    // Descriptor FIFO, first-word-fall-through; a push never meets a full FIFO because full blocks new packets.
    always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DESC_DEPTH; i++) begin
                r_desc_addr_mem[i] <= '0;
                r_desc_size_mem[i] <= '0;
            end
            r_fifo_rd  <= '0;
            r_fifo_wr  <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_desc_addr_mem[r_fifo_wr] <= r_cptr;
                r_desc_size_mem[r_fifo_wr] <= w_commit_size;
                r_fifo_wr                  <= r_fifo_wr + DESC_DEPTH_W'(1);
            end
            if (w_pop) begin
                r_fifo_rd <= r_fifo_rd + DESC_DEPTH_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + (DESC_DEPTH_W+1)'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - (DESC_DEPTH_W+1)'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

endmodule
